// File: rtl/rm_pkg.sv
// Shared types and helpers for the rule-monitor violation reporter.
// Record layout and lowest-set-bit grant used by the reporter and its FIFO.
package rm_pkg;

  localparam int RM_NUM_RULES = 149;
  localparam int RM_ID_W      = $clog2(RM_NUM_RULES);
  localparam int RM_TS_W      = 16;

  typedef struct packed {
    logic [RM_ID_W-1:0] id;
    logic [RM_TS_W-1:0] ts;
  } rm_viol_t;

  function automatic logic [RM_NUM_RULES-1:0] rm_lsb_onehot(
    input logic [RM_NUM_RULES-1:0] v
  );
    return v & (-v);
  endfunction

endpackage

// File: rtl/rm_violation_reporter_if.sv
// Valid/ready record channel from the violation reporter to the CSR side.
// The reporter drives the master modport, the consumer the slave one.
interface rm_violation_reporter_if
  import rm_pkg::*;
#(
  parameter int ID_W = RM_ID_W,
  parameter int TS_W = RM_TS_W
);

  logic            viol_valid_o;
  logic            viol_ready_i;
  logic [ID_W-1:0] viol_id_o;
  logic [TS_W-1:0] viol_ts_o;

  modport master (
    output viol_valid_o,
    output viol_id_o,
    output viol_ts_o,
    input  viol_ready_i
  );

  modport slave (
    input  viol_valid_o,
    input  viol_id_o,
    input  viol_ts_o,
    output viol_ready_i
  );

endinterface

// File: rtl/rm_viol_fifo.sv
// Synchronous FIFO of violation records with registered storage.
// Head is read straight from storage so it is stable until popped.
module rm_viol_fifo
  import rm_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic     clk_i,
  input  logic     rst_i,
  input  logic     push_i,
  input  rm_viol_t data_i,
  input  logic     pop_i,
  output rm_viol_t data_o,
  output logic     full_o,
  output logic     empty_o,
  output logic [AW:0] count_o
);

  rm_viol_t      mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign do_pop  = pop_i & (count != '0);
  assign do_push = push_i & (!full_o | do_pop);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wptr] <= data_i;
        wptr      <= wptr + AW'(1);
      end
      if (do_pop) begin
        rptr <= rptr + AW'(1);
      end
      count <= count + (AW+1)'(do_push)
                     - (AW+1)'(do_pop);
    end
  end

  assign data_o  = mem[rptr];
  assign full_o  = (count == (AW+1)'(DEPTH));
  assign empty_o = (count == '0);
  assign count_o = count;

endmodule

// File: rtl/rm_violation_reporter.sv
// Captures rule-flag rising edges, serialises them lowest-index-first
// into a record FIFO, and tracks coalesced events and the interrupt.
module rm_violation_reporter
  import rm_pkg::*;
#(
  parameter int NUM_RULES  = RM_NUM_RULES,
  parameter int FIFO_DEPTH = 8,
  parameter int TS_W       = RM_TS_W,
  parameter int DROP_W     = 8
) (
  input  logic                 clk_i,
  input  logic                 lane_reset_i,
  input  logic [NUM_RULES-1:0] monitor_i,
  input  logic [NUM_RULES-1:0] mask_i,
  input  logic                 enable_i,
  input  logic                 clear_i,
  rm_violation_reporter_if.master viol,
  output logic [NUM_RULES-1:0] pending_o,
  output logic                 overflow_o,
  output logic [DROP_W-1:0]    drop_cnt_o,
  output logic                 irq_o
);

  localparam int ID_W = $clog2(NUM_RULES);
  localparam int CW   = $clog2(FIFO_DEPTH) + 1;
  localparam int PC_W = $clog2(NUM_RULES + 1);
  localparam int SW   =
    (DROP_W > PC_W ? DROP_W : PC_W) + 1;

  logic [NUM_RULES-1:0] monitor_q;
  logic [NUM_RULES-1:0] pending;
  logic [NUM_RULES-1:0] rise;
  logic [NUM_RULES-1:0] grant_oh;
  logic [NUM_RULES-1:0] drops;
  logic [NUM_RULES-1:0] pending_next;
  logic [ID_W-1:0]      grant_idx;
  logic [TS_W-1:0]      ts;
  logic [PC_W-1:0]      drop_pc;
  logic [SW-1:0]        drop_sum;
  logic [DROP_W-1:0]    drop_base;
  logic [DROP_W-1:0]    drop_next;
  logic                 overflow_next;
  logic                 push;
  logic                 pop;
  logic                 push_ok;
  logic                 full;
  logic                 empty;
  logic [CW-1:0]        count;
  logic [CW-1:0]        count_next;
  rm_viol_t             wrec;
  rm_viol_t             head;

  assign rise = monitor_i & ~monitor_q & ~mask_i
              & {NUM_RULES{enable_i}};

  assign pop      = viol.viol_valid_o & viol.viol_ready_i;
  assign push_ok  = !full | pop;
  assign grant_oh = (pending != '0 && push_ok)
                  ? rm_lsb_onehot(pending) : '0;
  assign push     = |grant_oh;

  // A bit granted this cycle may rise again without being a drop.
  assign drops        = pending & ~grant_oh & rise;
  assign pending_next = (pending & ~grant_oh) | rise;

  always_comb begin
    grant_idx = '0;
    for (int i = NUM_RULES - 1; i >= 0; i--) begin
      if (pending[i]) grant_idx = ID_W'(i);
    end
  end

  always_comb begin
    drop_pc = '0;
    for (int i = 0; i < NUM_RULES; i++) begin
      drop_pc = drop_pc + PC_W'(drops[i]);
    end
  end

  assign drop_base = clear_i ? '0 : drop_cnt_o;
  assign drop_sum  = SW'(drop_base) + SW'(drop_pc);
  assign drop_next =
    (drop_sum > SW'({DROP_W{1'b1}}))
      ? '1 : DROP_W'(drop_sum);
  assign overflow_next =
    (overflow_o & ~clear_i) | (drops != '0);

  assign count_next = count + CW'(push) - CW'(pop);

  assign wrec = '{id: grant_idx, ts: ts};

  rm_viol_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (lane_reset_i),
    .push_i  (push),
    .data_i  (wrec),
    .pop_i   (pop),
    .data_o  (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (count)
  );

  assign viol.viol_valid_o = ~empty;
  assign viol.viol_id_o    = head.id;
  assign viol.viol_ts_o    = head.ts;

  always_ff @(posedge clk_i) begin
    if (lane_reset_i) begin
      monitor_q  <= '0;
      pending    <= '0;
      ts         <= '0;
      overflow_o <= 1'b0;
      drop_cnt_o <= '0;
      irq_o      <= 1'b0;
    end else begin
      monitor_q  <= monitor_i;
      pending    <= pending_next;
      ts         <= ts + TS_W'(1);
      overflow_o <= overflow_next;
      drop_cnt_o <= drop_next;
      irq_o      <= (count_next != '0)
                  | (pending_next != '0)
                  | overflow_next;
    end
  end

  assign pending_o = pending;

endmodule

// File: tb/tb_rm_violation_reporter.sv
// Scenario bench for rm_violation_reporter with a record scoreboard.
// Expected records are queued at stimulus time and checked on handshake.
module tb_rm_violation_reporter;
  import rm_pkg::*;

  localparam int NR = 149;

  typedef struct {
    int id;
    int ts;
  } exp_t;

  logic          clk = 1'b0;
  logic          lane_reset;
  logic [NR-1:0] monitor;
  logic [NR-1:0] mask;
  logic          enable;
  logic          clear;
  logic [NR-1:0] pending;
  logic          overflow;
  logic [7:0]    drop_cnt;
  logic          irq;

  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  exp_t sbq[$];

  always #5 clk = ~clk;

  rm_violation_reporter_if vif ();

  rm_violation_reporter dut (
    .clk_i        (clk),
    .lane_reset_i (lane_reset),
    .monitor_i    (monitor),
    .mask_i       (mask),
    .enable_i     (enable),
    .clear_i      (clear),
    .viol         (vif),
    .pending_o    (pending),
    .overflow_o   (overflow),
    .drop_cnt_o   (drop_cnt),
    .irq_o        (irq)
  );

  // Cycle index since reset release; equals the expected timestamp.
  always @(posedge clk) cyc <= lane_reset ? 0 : cyc + 1;

  always @(negedge clk) begin
    if (!lane_reset && vif.viol_valid_o
        && vif.viol_ready_i) begin
      exp_t e;
      n_checks++;
      if (sbq.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected: got id=%0d ts=%0d, required none",
                 vif.viol_id_o, vif.viol_ts_o);
      end else begin
        e = sbq.pop_front();
        if (int'(vif.viol_id_o) !== e.id
            || int'(vif.viol_ts_o) !== e.ts) begin
          n_fail++;
          $display("FAIL sb_record: got id=%0d ts=%0d, required id=%0d ts=%0d",
                   vif.viol_id_o, vif.viol_ts_o, e.id, e.ts);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_cyc(input int c);
    int g = 0;
    while (cyc < c && g < 200) begin
      tick(1);
      g++;
    end
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 60; i++) begin
      if (sbq.size() == 0 && !vif.viol_valid_o) break;
      tick(1);
    end
    n_checks++;
    if (sbq.size() != 0 || vif.viol_valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL drain: got left=%0d valid=%b, required left=0 valid=0",
               sbq.size(), vif.viol_valid_o);
    end
  endtask

  task automatic test_reset();
    lane_reset = 1'b1;
    monitor = '0;
    mask = '0;
    enable = 1'b1;
    clear = 1'b0;
    vif.viol_ready_i = 1'b1;
    tick(3);
    n_checks++;
    if ({vif.viol_valid_o, vif.viol_id_o, vif.viol_ts_o,
         overflow, drop_cnt, irq} !== '0) begin
      n_fail++;
      $display("FAIL reset_outs: got v=%b id=%0d ts=%0d ov=%b dc=%0d irq=%b, required all 0",
               vif.viol_valid_o, vif.viol_id_o, vif.viol_ts_o,
               overflow, drop_cnt, irq);
    end
    n_checks++;
    if (pending !== '0) begin
      n_fail++;
      $display("FAIL reset_pending: got %0d bits, required 0",
               $countones(pending));
    end
    lane_reset = 1'b0;
  endtask

  task automatic test_single();
    wait_cyc(10);
    monitor[5] = 1'b1;
    sbq.push_back('{5, 11});
    tick(1);
    n_checks++;
    if (vif.viol_valid_o !== 1'b0 || pending[5] !== 1'b1
        || irq !== 1'b1) begin
      n_fail++;
      $display("FAIL single_n1: got v=%b p5=%b irq=%b, required v=0 p5=1 irq=1",
               vif.viol_valid_o, pending[5], irq);
    end
    tick(1);
    n_checks++;
    if (vif.viol_valid_o !== 1'b1 || vif.viol_id_o !== 8'd5
        || vif.viol_ts_o !== 16'd11) begin
      n_fail++;
      $display("FAIL single_n2: got v=%b id=%0d ts=%0d, required v=1 id=5 ts=11",
               vif.viol_valid_o, vif.viol_id_o, vif.viol_ts_o);
    end
    monitor[5] = 1'b0;
    tick(5);
    n_checks++;
    if (vif.viol_valid_o !== 1'b0 || pending !== '0
        || irq !== 1'b0) begin
      n_fail++;
      $display("FAIL single_idle: got v=%b pend=%0d irq=%b, required 0 0 0",
               vif.viol_valid_o, $countones(pending), irq);
    end
    wait_drain();
  endtask

  task automatic test_multi();
    int c = cyc;
    monitor[3] = 1'b1;
    monitor[70] = 1'b1;
    monitor[148] = 1'b1;
    sbq.push_back('{3, c + 1});
    sbq.push_back('{70, c + 2});
    sbq.push_back('{148, c + 3});
    tick(1);
    monitor = '0;
    n_checks++;
    if ($countones(pending) != 3) begin
      n_fail++;
      $display("FAIL multi_pend: got %0d bits, required 3",
               $countones(pending));
    end
    tick(3);
    n_checks++;
    if (pending !== '0) begin
      n_fail++;
      $display("FAIL multi_empty: got %0d bits, required 0",
               $countones(pending));
    end
    wait_drain();
  endtask

  task automatic test_full();
    int c = cyc;
    int d;
    vif.viol_ready_i = 1'b0;
    for (int r = 20; r < 30; r++) monitor[r] = 1'b1;
    for (int k = 0; k < 8; k++) sbq.push_back('{20 + k, c + 1 + k});
    tick(1);
    monitor = '0;
    tick(9);
    n_checks++;
    if ($countones(pending) != 2 || pending[28] !== 1'b1
        || pending[29] !== 1'b1 || overflow !== 1'b0
        || vif.viol_valid_o !== 1'b1) begin
      n_fail++;
      $display("FAIL full_hold: got pend=%0d ov=%b v=%b, required pend=2 ov=0 v=1",
               $countones(pending), overflow, vif.viol_valid_o);
    end
    d = cyc;
    vif.viol_ready_i = 1'b1;
    sbq.push_back('{28, d});
    sbq.push_back('{29, d + 1});
    wait_drain();
  endtask

  task automatic test_coalesce();
    int c = cyc;
    int d;
    vif.viol_ready_i = 1'b0;
    for (int r = 30; r < 38; r++) monitor[r] = 1'b1;
    for (int k = 0; k < 8; k++) sbq.push_back('{30 + k, c + 1 + k});
    tick(1);
    monitor = '0;
    tick(9);
    for (int k = 0; k < 3; k++) begin
      monitor[7] = 1'b1;
      tick(1);
      monitor[7] = 1'b0;
      tick(1);
    end
    n_checks++;
    if (drop_cnt !== 8'd2 || overflow !== 1'b1
        || pending[7] !== 1'b1 || irq !== 1'b1) begin
      n_fail++;
      $display("FAIL coalesce: got dc=%0d ov=%b p7=%b irq=%b, required dc=2 ov=1 p7=1 irq=1",
               drop_cnt, overflow, pending[7], irq);
    end
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    n_checks++;
    if (drop_cnt !== 8'd0 || overflow !== 1'b0
        || pending[7] !== 1'b1) begin
      n_fail++;
      $display("FAIL clear: got dc=%0d ov=%b p7=%b, required dc=0 ov=0 p7=1",
               drop_cnt, overflow, pending[7]);
    end
    monitor[7] = 1'b1;
    clear = 1'b1;
    tick(1);
    monitor[7] = 1'b0;
    n_checks++;
    if (drop_cnt !== 8'd1 || overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL clear_vs_drop: got dc=%0d ov=%b, required dc=1 ov=1",
               drop_cnt, overflow);
    end
    tick(1);
    clear = 1'b0;
    d = cyc;
    vif.viol_ready_i = 1'b1;
    sbq.push_back('{7, d});
    wait_drain();
  endtask

  task automatic test_mask();
    mask[9] = 1'b1;
    monitor[9] = 1'b1;
    tick(1);
    monitor[9] = 1'b0;
    enable = 1'b0;
    monitor[4] = 1'b1;
    tick(1);
    monitor[4] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick(1);
      n_checks++;
      if (irq !== 1'b0 || vif.viol_valid_o !== 1'b0
          || pending !== '0) begin
        n_fail++;
        $display("FAIL mask_quiet: got irq=%b v=%b pend=%0d, required 0 0 0",
                 irq, vif.viol_valid_o, $countones(pending));
      end
    end
    enable = 1'b1;
    monitor[9] = 1'b1;
    tick(2);
    mask[9] = 1'b0;
    tick(4);
    n_checks++;
    if (irq !== 1'b0 || vif.viol_valid_o !== 1'b0
        || pending !== '0) begin
      n_fail++;
      $display("FAIL unmask_high: got irq=%b v=%b pend=%0d, required 0 0 0",
               irq, vif.viol_valid_o, $countones(pending));
    end
    monitor[9] = 1'b0;
    mask = '0;
    tick(2);
  endtask

  task automatic test_reset_mid();
    vif.viol_ready_i = 1'b0;
    for (int r = 40; r < 44; r++) monitor[r] = 1'b1;
    tick(1);
    monitor = '0;
    tick(5);
    n_checks++;
    if (vif.viol_valid_o !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_queued: got v=%b, required 1",
               vif.viol_valid_o);
    end
    lane_reset = 1'b1;
    sbq.delete();
    tick(1);
    lane_reset = 1'b0;
    n_checks++;
    if (vif.viol_valid_o !== 1'b0 || pending !== '0
        || irq !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset: got v=%b pend=%0d irq=%b, required 0 0 0",
               vif.viol_valid_o, $countones(pending), irq);
    end
    vif.viol_ready_i = 1'b1;
    wait_cyc(3);
    monitor[50] = 1'b1;
    sbq.push_back('{50, 4});
    tick(1);
    monitor = '0;
    wait_drain();
  endtask

  initial begin
    test_reset();
    test_single();
    test_multi();
    test_full();
    test_coalesce();
    test_mask();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish, required finish");
    $fatal(1, "timeout");
  end

endmodule
